// File: rtl/color_pkg.sv
// Shared class encoding, widths and debounce state encoding for the colour path.
package color_pkg;

  localparam int CLS_W  = 3;
  localparam int NORM_W = 16;

  localparam logic [CLS_W-1:0] CLS_NONE    = 3'd0;
  localparam logic [CLS_W-1:0] CLS_RED     = 3'd1;
  localparam logic [CLS_W-1:0] CLS_GREEN   = 3'd2;
  localparam logic [CLS_W-1:0] CLS_BLUE    = 3'd3;
  localparam logic [CLS_W-1:0] CLS_UNKNOWN = 3'd4;
  localparam logic [CLS_W-1:0] CLS_DARK    = 3'd5;

  // Channel index of the dominant component as reported by rgb_max2
  localparam logic [1:0] IDX_RED   = 2'd0;
  localparam logic [1:0] IDX_GREEN = 2'd1;
  localparam logic [1:0] IDX_BLUE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_STABLE    = 2'd2
  } state_t;

  function automatic logic [CLS_W-1:0] idx_to_class(input logic [1:0] idx);
    case (idx)
      IDX_RED:   return CLS_RED;
      IDX_GREEN: return CLS_GREEN;
      default:   return CLS_BLUE;
    endcase
  endfunction

endpackage

// File: rtl/color_classifier_rgb_max2.sv
// Registered max / runner-up finder over an RGB triplet. Ties go to the
// earlier channel (red, then green, then blue).
module rgb_max2
  import color_pkg::*;
#(
  parameter int W = NORM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] red,
  input  logic [W-1:0] green,
  input  logic [W-1:0] blue,
  input  logic         luz_in,
  output logic         out_valid,
  output logic [W-1:0] max_val,
  output logic [W-1:0] second_val,
  output logic [1:0]   max_idx,
  output logic         luz_out
);

  logic [W-1:0] m, s;
  logic [1:0]   idx;

  // Dominant channel with red > green > blue tie priority, plus the larger of the other two
  always_comb begin
    if (red >= green && red >= blue) begin
      idx = IDX_RED;
      m   = red;
      s   = (green >= blue) ? green : blue;
    end else if (green >= blue) begin
      idx = IDX_GREEN;
      m   = green;
      s   = (red >= blue) ? red : blue;
    end else begin
      idx = IDX_BLUE;
      m   = blue;
      s   = (red >= green) ? red : green;
    end
  end

  // Capture the result alongside luz whenever a sample arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      max_val    <= '0;
      second_val <= '0;
      max_idx    <= IDX_RED;
      luz_out    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        max_val    <= m;
        second_val <= s;
        max_idx    <= idx;
        luz_out    <= luz_in;
      end
    end
  end

endmodule

// File: rtl/color_classifier.sv
// Classifies normalized RGB samples, debounces the class over consecutive
// samples and drops back to NONE when the sensor front end goes quiet.
module color_classifier
  import color_pkg::*;
#(
  parameter logic [NORM_W-1:0] MIN_LEVEL      = 16'd20,
  parameter logic [NORM_W-1:0] MARGIN         = 16'd10,
  parameter int                STABLE_COUNT   = 3,
  parameter logic [31:0]       TIMEOUT_CYCLES = 32'd60_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [NORM_W-1:0] red_norm,
  input  logic [NORM_W-1:0] green_norm,
  input  logic [NORM_W-1:0] blue_norm,
  input  logic              luz,
  output logic [CLS_W-1:0]  raw_class,
  output logic              raw_valid,
  output logic [CLS_W-1:0]  color_out,
  output logic              color_changed,
  output logic [3:0]        confidence,
  output logic              stale
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_COUNT);

  logic              s1_valid, s1_luz;
  logic [NORM_W-1:0] s1_max, s1_second;
  logic [1:0]        s1_idx;

  rgb_max2 #(.W(NORM_W)) u_max2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (sample_valid),
    .red        (red_norm),
    .green      (green_norm),
    .blue       (blue_norm),
    .luz_in     (luz),
    .out_valid  (s1_valid),
    .max_val    (s1_max),
    .second_val (s1_second),
    .max_idx    (s1_idx),
    .luz_out    (s1_luz)
  );

  logic [CLS_W-1:0] next_class;

  // Raw class rule: dark wins, then level floor, then dominance margin (M >= S, no underflow)
  always_comb begin
    next_class = idx_to_class(s1_idx);
    if (s1_luz)                               next_class = CLS_DARK;
    else if (s1_max < MIN_LEVEL)              next_class = CLS_UNKNOWN;
    else if ((s1_max - s1_second) < MARGIN)   next_class = CLS_UNKNOWN;
  end

  // Stage 2 register: raw class and its strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_class <= CLS_NONE;
      raw_valid <= 1'b0;
    end else begin
      raw_valid <= s1_valid;
      if (s1_valid) raw_class <= next_class;
    end
  end

  state_t           state;
  logic [CLS_W-1:0] candidate;
  logic [31:0]      wdog;
  logic             match, expire;
  logic [3:0]       nconf;

  // Run-length bookkeeping: in STABLE the run is measured against the committed colour
  always_comb begin
    match = 1'b0;
    if (state == ST_STABLE)         match = (raw_class == color_out);
    else if (state == ST_CANDIDATE) match = (raw_class == candidate);
    nconf = 4'd1;
    if (match) nconf = (confidence == 4'd15) ? 4'd15 : confidence + 4'd1;
    expire = !sample_valid && (wdog != TIMEOUT_CYCLES) && (wdog + 32'd1 == TIMEOUT_CYCLES);
  end

  // Debounce FSM and watchdog; expiry overrides any debounce update in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      candidate     <= CLS_NONE;
      color_out     <= CLS_NONE;
      color_changed <= 1'b0;
      confidence    <= 4'd0;
      stale         <= 1'b0;
      wdog          <= '0;
    end else begin
      color_changed <= 1'b0;
      if (sample_valid) begin
        wdog  <= '0;
        stale <= 1'b0;
      end else if (wdog != TIMEOUT_CYCLES) begin
        wdog <= wdog + 32'd1;
      end
      if (raw_valid) begin
        confidence <= nconf;
        candidate  <= raw_class;
        if (state == ST_STABLE && match) begin
          state <= ST_STABLE;
        end else if (nconf >= STABLE_CNT) begin
          state         <= ST_STABLE;
          color_out     <= raw_class;
          color_changed <= (raw_class != color_out);
        end else begin
          state <= ST_CANDIDATE;
        end
      end
      if (expire) begin
        stale         <= 1'b1;
        color_out     <= CLS_NONE;
        color_changed <= (color_out != CLS_NONE);
        confidence    <= 4'd0;
        state         <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_color_classifier.sv
// Scoreboard bench: stimulus pushes expected raw classes / colour changes,
// negedge monitors pop and compare whenever the DUT strobes.
module tb_color_classifier;
  import color_pkg::*;

  typedef struct {
    logic [2:0] cls;
    int         t;
  } raw_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] red_norm = '0, green_norm = '0, blue_norm = '0;
  logic        luz = 1'b0;
  logic [2:0]  raw_class, color_out;
  logic        raw_valid, color_changed, stale;
  logic [3:0]  confidence;

  logic        t2_valid = 1'b0;
  logic [15:0] t2_r = '0, t2_g = '0, t2_b = '0;
  logic [2:0]  t2_raw_class, t2_color_out;
  logic        t2_raw_valid, t2_color_changed, t2_stale;
  logic [3:0]  t2_confidence;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_t = 0;
  raw_exp_t   rq[$];
  raw_exp_t   q2[$];
  logic [2:0] cq[$];
  raw_exp_t   me, me2;

  color_classifier #(
    .MIN_LEVEL(16'd20), .MARGIN(16'd10), .STABLE_COUNT(3), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .red_norm(red_norm), .green_norm(green_norm), .blue_norm(blue_norm), .luz(luz),
    .raw_class(raw_class), .raw_valid(raw_valid), .color_out(color_out),
    .color_changed(color_changed), .confidence(confidence), .stale(stale)
  );

  color_classifier #(
    .MIN_LEVEL(16'd20), .MARGIN(16'd0), .STABLE_COUNT(3), .TIMEOUT_CYCLES(32'd100)
  ) dut_tie (
    .clk(clk), .rst(rst), .sample_valid(t2_valid),
    .red_norm(t2_r), .green_norm(t2_g), .blue_norm(t2_b), .luz(1'b0),
    .raw_class(t2_raw_class), .raw_valid(t2_raw_valid), .color_out(t2_color_out),
    .color_changed(t2_color_changed), .confidence(t2_confidence), .stale(t2_stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                      input logic l, input logic [2:0] exp);
    raw_exp_t e;
    e.cls = exp;
    e.t   = cyc;
    rq.push_back(e);
    last_t       = cyc;
    sample_valid = 1'b1;
    red_norm = r; green_norm = g; blue_norm = b; luz = l;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send2(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                       input logic [2:0] exp);
    raw_exp_t e;
    e.cls = exp;
    e.t   = cyc;
    q2.push_back(e);
    t2_valid = 1'b1;
    t2_r = r; t2_g = g; t2_b = b;
    @(negedge clk);
    t2_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every DUT strobe is matched against the scoreboard queues
  always @(negedge clk) begin
    if (raw_valid) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL raw_unexpected got=%0d want=none", raw_class);
      end else begin
        me = rq.pop_front();
        chk("raw_class", raw_class, me.cls);
        chk("raw_latency", cyc - me.t, 2);
      end
    end
    if (color_changed) begin
      if (cq.size() == 0) begin
        checks++; failures++;
        $display("FAIL change_unexpected got=%0d want=none", color_out);
      end else begin
        chk("change_value", color_out, cq.pop_front());
      end
    end
    if (t2_raw_valid) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL tie_unexpected got=%0d want=none", t2_raw_class);
      end else begin
        me2 = q2.pop_front();
        chk("tie_class", t2_raw_class, me2.cls);
      end
    end
    if (t2_color_changed) begin
      checks++; failures++;
      $display("FAIL tie_change_unexpected got=%0d want=none", t2_color_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    // Reset state
    gap(3);
    chk("rst_raw_class", raw_class, 0);
    chk("rst_raw_valid", raw_valid, 0);
    chk("rst_color_out", color_out, 0);
    chk("rst_changed", color_changed, 0);
    chk("rst_confidence", confidence, 0);
    chk("rst_stale", stale, 0);
    rst = 1'b0;
    gap(2);

    // Three RED samples 10 cycles apart commit RED
    send(16'd80, 16'd30, 16'd20, 1'b0, CLS_RED); gap(9);
    send(16'd80, 16'd30, 16'd20, 1'b0, CLS_RED); gap(9);
    chk("red_not_yet", color_out, 0);
    cq.push_back(CLS_RED);
    send(16'd80, 16'd30, 16'd20, 1'b0, CLS_RED); gap(5);
    chk("red_color", color_out, CLS_RED);
    chk("red_conf", confidence, 3);

    // Margin, level floor and dark rules
    send(16'd50, 16'd45, 16'd10, 1'b0, CLS_UNKNOWN); gap(4);
    send(16'd15, 16'd5,  16'd0,  1'b0, CLS_UNKNOWN); gap(4);
    send(16'd80, 16'd30, 16'd20, 1'b1, CLS_DARK);    gap(4);
    send(16'd0,  16'd0,  16'd0,  1'b1, CLS_DARK);    gap(4);
    chk("hold_red", color_out, CLS_RED);
    chk("dark_conf", confidence, 2);

    // Re-commit RED: no change pulse expected
    repeat (3) begin send(16'd80, 16'd30, 16'd20, 1'b0, CLS_RED); gap(4); end
    chk("recommit_red", color_out, CLS_RED);
    chk("recommit_conf", confidence, 3);

    // GREEN, GREEN, RED, GREEN x3
    send(16'd10, 16'd90, 16'd10, 1'b0, CLS_GREEN); gap(4);
    send(16'd10, 16'd90, 16'd10, 1'b0, CLS_GREEN); gap(4);
    send(16'd80, 16'd30, 16'd20, 1'b0, CLS_RED);   gap(4);
    send(16'd10, 16'd90, 16'd10, 1'b0, CLS_GREEN); gap(4);
    send(16'd10, 16'd90, 16'd10, 1'b0, CLS_GREEN); gap(4);
    chk("green_pending", color_out, CLS_RED);
    chk("green_pending_conf", confidence, 2);
    cq.push_back(CLS_GREEN);
    send(16'd10, 16'd90, 16'd10, 1'b0, CLS_GREEN); gap(4);
    chk("green_color", color_out, CLS_GREEN);

    // Commit BLUE, then let the watchdog expire
    send(16'd10, 16'd10, 16'd90, 1'b0, CLS_BLUE); gap(4);
    send(16'd10, 16'd10, 16'd90, 1'b0, CLS_BLUE); gap(4);
    cq.push_back(CLS_BLUE);
    send(16'd10, 16'd10, 16'd90, 1'b0, CLS_BLUE); gap(4);
    chk("blue_color", color_out, CLS_BLUE);
    cq.push_back(CLS_NONE);
    t0 = last_t;
    while (cyc < t0 + 100) @(negedge clk);
    chk("stale_before", stale, 0);
    chk("color_before", color_out, CLS_BLUE);
    @(negedge clk);
    chk("stale_set", stale, 1);
    chk("stale_color", color_out, CLS_NONE);
    chk("stale_conf", confidence, 0);
    gap(20);
    chk("stale_hold", stale, 1);

    // Next sample clears stale and restarts the run from IDLE
    send(16'd10, 16'd10, 16'd90, 1'b0, CLS_BLUE);
    chk("stale_cleared", stale, 0);
    gap(4);
    chk("restart_conf", confidence, 1);

    // Sample landing exactly on the expiry cycle wins
    t0 = last_t;
    while (cyc < t0 + 100) @(negedge clk);
    send(16'd10, 16'd10, 16'd90, 1'b0, CLS_BLUE);
    chk("expiry_race_stale", stale, 0);
    gap(4);
    chk("expiry_race_conf", confidence, 2);
    cq.push_back(CLS_BLUE);
    send(16'd10, 16'd10, 16'd90, 1'b0, CLS_BLUE); gap(4);
    chk("blue_again", color_out, CLS_BLUE);

    // Back-to-back strobes: none dropped
    cq.push_back(CLS_RED);
    send(16'd80, 16'd30, 16'd20, 1'b0, CLS_RED);
    send(16'd80, 16'd30, 16'd20, 1'b0, CLS_RED);
    send(16'd80, 16'd30, 16'd20, 1'b0, CLS_RED);
    gap(4);
    chk("b2b_color", color_out, CLS_RED);
    chk("b2b_conf", confidence, 3);

    // Reset one cycle after a strobe discards the in-flight sample
    sample_valid = 1'b1;
    red_norm = 16'd10; green_norm = 16'd90; blue_norm = 16'd10; luz = 1'b0;
    @(negedge clk);
    sample_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_raw_valid", raw_valid, 0);
    chk("mid_rst_raw_class", raw_class, 0);
    chk("mid_rst_color", color_out, 0);
    chk("mid_rst_conf", confidence, 0);
    chk("mid_rst_stale", stale, 0);
    rst = 1'b0;
    gap(8);

    // Tie priority with zero margin
    send2(16'd60, 16'd60, 16'd0, CLS_RED);   gap(4);
    send2(16'd0,  16'd60, 16'd60, CLS_GREEN); gap(4);
    send2(16'd30, 16'd30, 16'd30, CLS_RED);  gap(4);
    chk("tie_conf", t2_confidence, 1);
    chk("tie_color", t2_color_out, 0);
    chk("tie_stale", t2_stale, 0);

    gap(4);
    chk("raw_queue_drained", rq.size(), 0);
    chk("change_queue_drained", cq.size(), 0);
    chk("tie_queue_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
